// File: rtl/game_pkg.sv
// Shared definitions for the flappy-bird game blocks.
//   game_state_t : run-control state encoding (IDLE=00, PLAY=01, OVER=10)
//   SCREEN_W/H   : visible screen size in pixels
//   LAUNCH_X_DEF : default x at which the next pipe is released
//   cnt_width()  : width of a down-counter that must hold 'hold' (min 1 bit)
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } game_state_t;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int LAUNCH_X_DEF = 213;

    // $clog2(1) is 0, which would give a zero-width counter for hold=0.
    function automatic int cnt_width(input int hold);
        return (hold > 0) ? $clog2(hold + 1) : 1;
    endfunction

endpackage

// File: rtl/key_event.sv
// Key conditioning: 2-flop synchronizer followed by a rising-edge detector.
//   clk, reset_n : clock, async active-low reset
//   in           : raw asynchronous key level
//   ev           : one-cycle event per press (held key gives one event)
module key_event (
    input  logic clk,
    input  logic reset_n,
    input  logic in,
    output logic ev
);

    logic sync1, sync2, prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign ev = sync2 & ~prev;

endmodule

// File: rtl/game_sequencer.sv
// Run-control FSM for the flappy-bird game.
//   clk, reset_n  : clock, async active-low reset
//   start_req     : start-game key (async)
//   bird_req      : bird-only key (async)
//   collision     : collision level (synchronous)
//   pipe_x0       : packed pipe left-edge x, pipe i at [i*X_W +: X_W]
//   pipe_start    : run enable per pipe mover
//   bird_start    : run enable for the bird mover
//   score_clear   : one-cycle pulse on every game start
//   game_over     : high while in OVER
//   clear_screen  : high while in OVER
//   state         : IDLE=00, PLAY=01, OVER=10
module game_sequencer
    import game_pkg::*;
#(
    parameter int N_PIPES     = 3,
    parameter int X_W         = 10,
    parameter int LAUNCH_X    = LAUNCH_X_DEF,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start_req,
    input  logic                   bird_req,
    input  logic                   collision,
    input  logic [N_PIPES*X_W-1:0] pipe_x0,
    output logic [N_PIPES-1:0]     pipe_start,
    output logic                   bird_start,
    output logic                   score_clear,
    output logic                   game_over,
    output logic                   clear_screen,
    output logic [1:0]             state
);

    localparam int                 CNT_W      = cnt_width(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]   HOLD_LOAD  = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;
    localparam logic [X_W-1:0]     LAUNCH_V   = X_W'(LAUNCH_X);
    localparam logic [N_PIPES-1:0] FIRST_PIPE = N_PIPES'(1);

    logic start_ev, bird_ev;

    key_event u_start_ev (.clk(clk), .reset_n(reset_n), .in(start_req), .ev(start_ev));
    key_event u_bird_ev  (.clk(clk), .reset_n(reset_n), .in(bird_req),  .ev(bird_ev));

    game_state_t        state_q, state_d;
    logic [N_PIPES-1:0] pipe_q, pipe_d;
    logic               bird_q, bird_d;
    logic               clr_q, clr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pipe_q  <= '0;
            bird_q  <= 1'b0;
            clr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pipe_q  <= pipe_d;
            bird_q  <= bird_d;
            clr_q   <= clr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pipe_d  = pipe_q;
        bird_d  = bird_q;
        clr_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_ev) begin
                    state_d = PLAY;
                    pipe_d  = FIRST_PIPE;
                    bird_d  = 1'b1;
                    clr_d   = 1'b1;
                end else if (bird_ev) begin
                    bird_d  = 1'b1;
                end
            end
            PLAY: begin
                // Collision outranks everything, including pipe launches.
                if (collision) begin
                    state_d = OVER;
                    pipe_d  = '0;
                    bird_d  = 1'b0;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    // Equality only: a pipe sweeping past LAUNCH_X fires once;
                    // launch bits are sticky so later passes change nothing.
                    for (int i = 1; i < N_PIPES; i++) begin
                        if (pipe_q[i-1] && (pipe_x0[(i-1)*X_W +: X_W] == LAUNCH_V))
                            pipe_d[i] = 1'b1;
                    end
                end
            end
            OVER: begin
                // Early start presses are dropped, never queued.
                if (start_ev && (cnt_q == '0)) begin
                    state_d = PLAY;
                    pipe_d  = FIRST_PIPE;
                    bird_d  = 1'b1;
                    clr_d   = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                pipe_d  = '0;
                bird_d  = 1'b0;
            end
        endcase
    end

    assign pipe_start   = pipe_q;
    assign bird_start   = bird_q;
    assign score_clear  = clr_q;
    assign game_over    = (state_q == OVER);
    assign clear_screen = (state_q == OVER);
    assign state        = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;

    localparam int NP   = 3;
    localparam int XW   = 10;
    localparam int LX   = 213;
    localparam int HOLD = 8;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start_req, bird_req, collision;
    logic [NP*XW-1:0]   pipe_x0;
    logic [NP-1:0]      pipe_start;
    logic               bird_start, score_clear, game_over, clear_screen;
    logic [1:0]         state;

    always #5 clk = ~clk;

    game_sequencer #(
        .N_PIPES(NP), .X_W(XW), .LAUNCH_X(LX), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start_req(start_req), .bird_req(bird_req),
        .collision(collision), .pipe_x0(pipe_x0), .pipe_start(pipe_start),
        .bird_start(bird_start), .score_clear(score_clear), .game_over(game_over),
        .clear_screen(clear_screen), .state(state)
    );

    int tests = 0;
    int errs  = 0;

    // ---------------- directed vectors ----------------
    typedef struct packed {
        logic       s, b, c;
        logic [9:0] x0, x1;
        logic [1:0] st;
        logic [2:0] pipe;
        logic       bird, sc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input int s, b, c, x0, x1, st, pipe, bird, sc);
        vec_t r;
        r.s = s[0]; r.b = b[0]; r.c = c[0];
        r.x0 = x0[9:0]; r.x1 = x1[9:0];
        r.st = st[1:0]; r.pipe = pipe[2:0]; r.bird = bird[0]; r.sc = sc[0];
        return r;
    endfunction

    // ---------------- reference model ----------------
    // Game state as plain integers; key events are the raw input delayed by
    // the two-sample latency, taken on a 0->1 change of the delayed value.
    int         m_st;       // 0 idle, 1 play, 2 over
    logic [2:0] m_pipe;
    logic       m_bird, m_sc;
    int         m_age;      // edges spent in OVER so far
    logic       hs1, hs2, hs3, hb1, hb2, hb3;

    task automatic model_reset();
        m_st = 0; m_pipe = 3'b000; m_bird = 1'b0; m_sc = 1'b0; m_age = 0;
        hs1 = 0; hs2 = 0; hs3 = 0; hb1 = 0; hb2 = 0; hb3 = 0;
    endtask

    task automatic model_edge();
        logic       evs, evb;
        logic [2:0] old;
        evs = hs2 & ~hs3;
        evb = hb2 & ~hb3;
        hs3 = hs2; hs2 = hs1; hs1 = start_req;
        hb3 = hb2; hb2 = hb1; hb1 = bird_req;
        m_sc = 1'b0;
        old  = m_pipe;
        if (m_st == 0) begin
            if (evs) begin m_st = 1; m_pipe = 3'b001; m_bird = 1; m_sc = 1; end
            else if (evb) m_bird = 1;
        end else if (m_st == 1) begin
            if (collision) begin m_st = 2; m_pipe = 3'b000; m_bird = 0; m_age = 0; end
            else begin
                for (int i = 1; i < NP; i++)
                    if (old[i-1] && (int'(pipe_x0[(i-1)*XW +: XW]) == LX)) m_pipe[i] = 1'b1;
            end
        end else begin
            m_age++;
            if (evs && m_age >= HOLD) begin m_st = 1; m_pipe = 3'b001; m_bird = 1; m_sc = 1; end
        end
    endtask

    // One clock: model follows the DUT's edge, outputs sampled on negedge.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset(); else model_edge();
        @(negedge clk);
    endtask

    task automatic check_model(input string name, input int cyc);
        logic ov;
        ov = (m_st == 2);
        tests++;
        if (state !== 2'(m_st) || pipe_start !== m_pipe || bird_start !== m_bird ||
            score_clear !== m_sc || game_over !== ov || clear_screen !== ov) begin
            errs++;
            $display("FAIL %s cyc %0d: got st=%b pipe=%b bird=%b sc=%b go=%b cs=%b want st=%0d pipe=%b bird=%b sc=%b go/cs=%b",
                     name, cyc, state, pipe_start, bird_start, score_clear, game_over, clear_screen,
                     m_st, m_pipe, m_bird, m_sc, ov);
        end
    endtask

    task automatic check_vec(input string name, input int idx, input vec_t e);
        logic ov;
        ov = (e.st == 2'b10);
        tests++;
        if (state !== e.st || pipe_start !== e.pipe || bird_start !== e.bird ||
            score_clear !== e.sc || game_over !== ov || clear_screen !== ov) begin
            errs++;
            $display("FAIL %s row %0d: got st=%b pipe=%b bird=%b sc=%b go=%b cs=%b want st=%b pipe=%b bird=%b sc=%b go/cs=%b",
                     name, idx, state, pipe_start, bird_start, score_clear, game_over, clear_screen,
                     e.st, e.pipe, e.bird, e.sc, ov);
        end
    endtask

    task automatic check_zero(input string name);
        tests++;
        if (state !== 2'b00 || pipe_start !== 3'b000 || bird_start !== 1'b0 ||
            score_clear !== 1'b0 || game_over !== 1'b0 || clear_screen !== 1'b0) begin
            errs++;
            $display("FAIL %s: got st=%b pipe=%b bird=%b sc=%b go=%b cs=%b want all zero",
                     name, state, pipe_start, bird_start, score_clear, game_over, clear_screen);
        end
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            start_req = tbl[i].s; bird_req = tbl[i].b; collision = tbl[i].c;
            pipe_x0   = {10'd0, tbl[i].x1, tbl[i].x0};
            tick();
            check_vec(name, i, tbl[i]);
        end
        start_req = 0; bird_req = 0; collision = 0; pipe_x0 = '0;
    endtask

    task automatic do_reset();
        start_req = 0; bird_req = 0; collision = 0; pipe_x0 = '0;
        reset_n = 0;
        model_reset();
        tick(); tick();
        reset_n = 1;
    endtask

    function automatic logic [9:0] pick_x();
        case ($urandom_range(0, 3))
            0: return 10'd212;
            1: return 10'd213;
            2: return 10'd214;
            default: return 10'($urandom_range(0, 639));
        endcase
    endfunction

    initial begin
        reset_n = 0; start_req = 0; bird_req = 0; collision = 0; pipe_x0 = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset_n = 1;

        // Start, staggered launches, collision, early restart ignored, late restart.
        tbl.delete();
        tbl.push_back(v(1,0,0,  0,  0, 0,3'b000,0,0));
        tbl.push_back(v(1,0,0,  0,  0, 0,3'b000,0,0));
        tbl.push_back(v(1,0,0,  0,  0, 1,3'b001,1,1));
        tbl.push_back(v(1,0,0,  0,  0, 1,3'b001,1,0));
        tbl.push_back(v(1,0,0,  0,  0, 1,3'b001,1,0));
        tbl.push_back(v(0,0,0,212,  0, 1,3'b001,1,0));
        tbl.push_back(v(0,0,0,213,  0, 1,3'b011,1,0));
        tbl.push_back(v(0,0,0,214,  0, 1,3'b011,1,0));
        tbl.push_back(v(0,0,0,214,213, 1,3'b111,1,0));
        tbl.push_back(v(0,0,0,214,  0, 1,3'b111,1,0));
        tbl.push_back(v(0,0,1,214,  0, 2,3'b000,0,0));
        tbl.push_back(v(1,0,0,  0,  0, 2,3'b000,0,0));
        tbl.push_back(v(0,0,0,  0,  0, 2,3'b000,0,0));
        for (int i = 0; i < 4; i++) tbl.push_back(v(0,0,0,213,0, 2,3'b000,0,0));
        tbl.push_back(v(1,0,0,  0,  0, 2,3'b000,0,0));
        tbl.push_back(v(1,0,0,  0,  0, 2,3'b000,0,0));
        tbl.push_back(v(0,0,0,  0,  0, 1,3'b001,1,1));
        tbl.push_back(v(0,0,0,  0,  0, 1,3'b001,1,0));
        tbl.push_back(v(0,0,1,  0,  0, 2,3'b000,0,0));
        run_table("play_seq");

        // Bird-only flight in IDLE, no launch from idle pipe, collision+start race.
        do_reset();
        tbl.delete();
        tbl.push_back(v(0,1,0,  0,0, 0,3'b000,0,0));
        tbl.push_back(v(0,1,0,  0,0, 0,3'b000,0,0));
        tbl.push_back(v(0,0,0,  0,0, 0,3'b000,1,0));
        tbl.push_back(v(0,0,0,213,0, 0,3'b000,1,0));
        tbl.push_back(v(1,0,0,213,0, 0,3'b000,1,0));
        tbl.push_back(v(0,0,0,213,0, 0,3'b000,1,0));
        tbl.push_back(v(0,0,0,213,0, 1,3'b001,1,1));
        tbl.push_back(v(0,0,0,  0,0, 1,3'b001,1,0));
        tbl.push_back(v(1,0,0,  0,0, 1,3'b001,1,0));
        tbl.push_back(v(0,0,0,  0,0, 1,3'b001,1,0));
        tbl.push_back(v(0,0,1,  0,0, 2,3'b000,0,0));
        tbl.push_back(v(0,1,0,  0,0, 2,3'b000,0,0));
        tbl.push_back(v(0,1,0,  0,0, 2,3'b000,0,0));
        for (int i = 0; i < 6; i++) tbl.push_back(v(0,0,0,0,0, 2,3'b000,0,0));
        tbl.push_back(v(1,0,0,  0,0, 2,3'b000,0,0));
        tbl.push_back(v(0,0,0,  0,0, 2,3'b000,0,0));
        tbl.push_back(v(0,0,0,  0,0, 1,3'b001,1,1));
        tbl.push_back(v(0,0,0,  0,0, 1,3'b001,1,0));
        run_table("bird_seq");

        // Asynchronous reset in the middle of PLAY.
        #2 reset_n = 0;
        #1 check_zero("async_reset");
        model_reset();
        tick();
        check_zero("reset_held");
        reset_n = 1;
        tick(); check_model("reset_release", 0);
        tick(); check_model("reset_release", 1);

        // Randomised run against the reference model.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 7) == 0) start_req = ~start_req;
            if ($urandom_range(0, 9) == 0) bird_req  = ~bird_req;
            collision = ($urandom_range(0, 29) == 0);
            pipe_x0   = {pick_x(), pick_x(), pick_x()};
            tick();
            check_model("random", cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
